soric_efpga_resp: RTL
=====================

SORIC_EFPGA_RESP -- requirements
Module: soric_efpga_resp

Interface
REQ-001 The block SHALL have one clock, clk_i, and one reset, rst_ni, which is asynchronous and active-low.
REQ-002 Parameter DATA_W, default 32: operand and result width.
REQ-003 Ports (name  direction  width  meaning):
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- eFPGA_en_i  in  1  request, 4-phase level
- eFPGA_operator_i  in  2  00 ADD, 01 SUB, 10 MUL, 11 MAC
- eFPGA_delay_i  in  2  extra BUSY cycles, 0..3
- eFPGA_operand_a_i  in  DATA_W  operand A
- eFPGA_operand_b_i  in  DATA_W  operand B
- eFPGA_write_strobe_i  in  1  config write; data on operand_a
- eFPGA_result_a_o  out  DATA_W  result A
- eFPGA_result_b_o  out  DATA_W  result B
- eFPGA_result_c_o  out  DATA_W  result C
- eFPGA_fpga_done_o  out  1  results valid
- irq_o  out  1  completion interrupt pending
- irq_id_o  out  5  interrupt id
- irq_ack_i  in  1  one-cycle interrupt acknowledge

Function
REQ-004 FSM states SHALL be IDLE, BUSY and DONE.
REQ-005 In IDLE with eFPGA_en_i=1 at a rising edge: latch operator, operands and delay; load cnt=delay; go to BUSY.
REQ-006 In BUSY: cnt!=0 -> decrement cnt; cnt==0 -> register results, go to DONE; eFPGA_en_i is ignored.
REQ-007 eFPGA_fpga_done_o SHALL be 1 exactly while in DONE, rising delay+1 edges after the accepting edge.
REQ-008 In DONE with eFPGA_en_i=0 -> IDLE; while eFPGA_en_i stays 1, remain in DONE (no retrigger).
REQ-009 ADD: A=a+b, B=carry-out zero-extended, C=a^b.
REQ-010 SUB: A=a-b, B=1 if a<b unsigned else 0, C=a&b.
REQ-011 MUL: unsigned 2*DATA_W product; A=low half, B=high half, C=a|b.
REQ-012 MAC: acc=acc+low(a*b) modulo 2^DATA_W, updated at BUSY->DONE; A=new acc, B=low(a*b), C=old acc.
REQ-013 Results SHALL hold their last values until the next BUSY->DONE transition.
REQ-014 Any cycle with eFPGA_write_strobe_i=1 SHALL load cfg from operand_a: bit0 irq_en, bits[5:1] irq_id. If bit6=1, acc SHALL be cleared. This applies in every state.
REQ-015 irq_id_o SHALL equal cfg irq_id.
REQ-016 On BUSY->DONE with irq_en=1, pending SHALL set. irq_ack_i=1 SHALL clear pending. If set and ack occur in the same cycle, set wins. irq_o=pending.
REQ-017 Clearing irq_en SHALL NOT clear an already-pending interrupt.
REQ-018 Operands changing after acceptance SHALL NOT affect the results.

Reset
REQ-019 When rst_ni=0 the block SHALL asynchronously enter IDLE and zero cnt, acc, cfg, pending and all results. All outputs SHALL read 0.
REQ-020 Reset asserted mid-BUSY or mid-DONE SHALL abort the operation; acc SHALL NOT update.
REQ-021 After reset release, the first acceptance SHALL occur no earlier than the first rising edge at which rst_ni=1 and eFPGA_en_i=1.

Structure
REQ-022 Package soric_efpga_pkg SHALL hold the operator encodings, the FSM state type and the cfg bit positions.
REQ-023 The datapath SHALL be a combinational sub-module soric_efpga_alu (operator, a, b, acc -> A, B, C, new acc), registered by the parent.

Verification
REQ-024 Bench SHALL cover the following scenarios:
- ADD a=FFFFFFFF, b=1, delay=0 -> done rises 1 edge after accept; A=0, B=1, C=FFFFFFFE.
- MUL a=FFFFFFFF, b=2, delay=3 -> done rises after 4 edges; A=FFFFFFFE, B=1; operand change during BUSY ignored.
- Config write 0x0000_0043 (irq_en, id=1, clear acc), then MAC a=3,b=4 twice -> A=12 then 24, C=12; irq_o=1, irq_id_o=1.
- irq_ack_i in the same cycle as a new completion -> irq_o stays 1; ack alone -> irq_o=0 next cycle.
- en held high through DONE -> single operation, done stays 1; en low -> IDLE next edge.
- rst_ni pulsed mid-BUSY of MAC -> all outputs 0, acc stays 0; next MAC a=2,b=5 -> A=10.

Source files
------------

// File: rtl/soric_efpga_pkg.sv
// Shared encodings for the eFPGA response model: operators, FSM states, cfg fields.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package soric_efpga_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_MAC = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Config word layout carried on operand_a during a write strobe
  localparam int CFG_IRQ_EN_BIT  = 0;
  localparam int CFG_ID_LSB      = 1;
  localparam int CFG_ID_MSB      = 5;
  localparam int CFG_ACC_CLR_BIT = 6;

endpackage

// File: rtl/soric_efpga_alu.sv
// Combinational datapath: computes the three results and the next accumulator.
// Latency: 0 cycles; the parent registers everything on BUSY->DONE.
// Backpressure: none, pure function of its inputs.
module soric_efpga_alu
  import soric_efpga_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  op_e               op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] acc,
  output logic [DATA_W-1:0] res_a,
  output logic [DATA_W-1:0] res_b,
  output logic [DATA_W-1:0] res_c,
  output logic [DATA_W-1:0] acc_nxt
);

  logic [2*DATA_W-1:0] prod;
  logic [DATA_W:0]     sum;
  logic [DATA_W-1:0]   mac_sum;

  assign prod    = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
  assign sum     = {1'b0, a} + {1'b0, b};
  assign mac_sum = acc + prod[DATA_W-1:0];

  // Operator select; accumulator only moves for MAC
  always_comb begin
    res_a   = '0;
    res_b   = '0;
    res_c   = '0;
    acc_nxt = acc;
    case (op)
      OP_ADD: begin
        res_a = sum[DATA_W-1:0];
        res_b = {{(DATA_W-1){1'b0}}, sum[DATA_W]};
        res_c = a ^ b;
      end
      OP_SUB: begin
        res_a = a - b;
        res_b = {{(DATA_W-1){1'b0}}, (a < b)};
        res_c = a & b;
      end
      OP_MUL: begin
        res_a = prod[DATA_W-1:0];
        res_b = prod[2*DATA_W-1:DATA_W];
        res_c = a | b;
      end
      OP_MAC: begin
        acc_nxt = mac_sum;
        res_a   = mac_sum;
        res_b   = prod[DATA_W-1:0];
        res_c   = acc;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/soric_efpga_resp.sv
// eFPGA accelerator response model: 4-phase request, programmable BUSY delay, irq on completion.
// Latency: done rises delay+1 edges after the accepting edge (delay = 0..3).
// Backpressure: requests are only accepted in IDLE; en is ignored in BUSY and must drop to leave DONE.
module soric_efpga_resp
  import soric_efpga_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              eFPGA_en_i,
  input  logic [1:0]        eFPGA_operator_i,
  input  logic [1:0]        eFPGA_delay_i,
  input  logic [DATA_W-1:0] eFPGA_operand_a_i,
  input  logic [DATA_W-1:0] eFPGA_operand_b_i,
  input  logic              eFPGA_write_strobe_i,
  output logic [DATA_W-1:0] eFPGA_result_a_o,
  output logic [DATA_W-1:0] eFPGA_result_b_o,
  output logic [DATA_W-1:0] eFPGA_result_c_o,
  output logic              eFPGA_fpga_done_o,
  output logic              irq_o,
  output logic [4:0]        irq_id_o,
  input  logic              irq_ack_i
);

  state_e            state;
  logic [1:0]        cnt;
  op_e               op_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] res_a, res_b, res_c;
  logic              done;
  logic              irq_en;
  logic [4:0]        irq_id;
  logic              pending;

  logic [DATA_W-1:0] alu_a, alu_b, alu_c, alu_acc;
  logic              finish;

  // Completion happens on the edge that leaves BUSY with the counter exhausted
  assign finish = (state == ST_BUSY) && (cnt == 2'd0);

  soric_efpga_alu #(.DATA_W(DATA_W)) u_alu (
    .op      (op_q),
    .a       (a_q),
    .b       (b_q),
    .acc     (acc),
    .res_a   (alu_a),
    .res_b   (alu_b),
    .res_c   (alu_c),
    .acc_nxt (alu_acc)
  );

  // Request FSM: latch the request, count out the delay, publish results, wait for en to drop
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ST_IDLE;
      cnt   <= '0;
      op_q  <= OP_ADD;
      a_q   <= '0;
      b_q   <= '0;
      res_a <= '0;
      res_b <= '0;
      res_c <= '0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (eFPGA_en_i) begin
            op_q  <= op_e'(eFPGA_operator_i);
            a_q   <= eFPGA_operand_a_i;
            b_q   <= eFPGA_operand_b_i;
            cnt   <= eFPGA_delay_i;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt != 2'd0) begin
            cnt <= cnt - 2'd1;
          end else begin
            res_a <= alu_a;
            res_b <= alu_b;
            res_c <= alu_c;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!eFPGA_en_i) begin
            done  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Config register and accumulator; a clear-acc write in the completion cycle beats the MAC update
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc    <= '0;
      irq_en <= 1'b0;
      irq_id <= '0;
    end else begin
      if (finish) begin
        acc <= alu_acc;
      end
      if (eFPGA_write_strobe_i) begin
        irq_en <= eFPGA_operand_a_i[CFG_IRQ_EN_BIT];
        irq_id <= eFPGA_operand_a_i[CFG_ID_MSB:CFG_ID_LSB];
        if (eFPGA_operand_a_i[CFG_ACC_CLR_BIT]) begin
          acc <= '0;
        end
      end
    end
  end

  // Pending interrupt: a new completion outranks a simultaneous acknowledge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending <= 1'b0;
    end else if (finish && irq_en) begin
      pending <= 1'b1;
    end else if (irq_ack_i) begin
      pending <= 1'b0;
    end
  end

  assign eFPGA_result_a_o  = res_a;
  assign eFPGA_result_b_o  = res_b;
  assign eFPGA_result_c_o  = res_c;
  assign eFPGA_fpga_done_o = done;
  assign irq_o             = pending;
  assign irq_id_o          = irq_id;

endmodule
